cache_mem_arbiter: RTL and testbench

//  Sequential arbiter between i_cache and d_cache memory ports and the single-outstanding axi_interface port.

---
 rtl/cache_mem_arbiter_if.sv | 58 +++++
 rtl/cache_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - cache/memory port bundle between i_cache, d_cache, arbiter and axi_interface
//
// Purpose: groups every signal the arbiter exchanges with the two caches and the
// memory port. The arbiter uses the master modport and the environment uses the slave modport.
// Ports (all logic):
//   i_strobe, i_addr                  i_cache request
//   i_ready, i_data                   i_cache completion / read data
//   d_strobe, d_addr, d_rw, d_size,
//   d_wen, d_wdata                    d_cache request
//   d_ready, d_rdata                  d_cache completion / read data
//   mem_a, mem_access, mem_write,
//   mem_size, mem_sel, mem_st_data    registered request to axi_interface
//   mem_ready, mem_data               axi_interface completion / read data
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_strobe;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;

  logic              d_strobe;
  logic [ADDR_W-1:0] d_addr;
  logic              d_rw;
  logic [1:0]        d_size;
  logic [3:0]        d_wen;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_a;
  logic              mem_access;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_st_data;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;

  modport master (
    input  i_strobe, i_addr,
    output i_ready, i_data,
    input  d_strobe, d_addr, d_rw, d_size, d_wen, d_wdata,
    output d_ready, d_rdata,
    output mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data,
    input  mem_ready, mem_data
  );

  modport slave (
    output i_strobe, i_addr,
    input  i_ready, i_data,
    output d_strobe, d_addr, d_rw, d_size, d_wen, d_wdata,
    input  d_ready, d_rdata,
    input  mem_a, mem_access, mem_write, mem_size, mem_sel, mem_st_data,
    output mem_ready, mem_data
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - sequential i_cache/d_cache arbiter in front of a single-outstanding memory port
//
// Purpose: grants one cache at a time, registers the granted request so it stays
// stable for the whole transaction, and routes mem_ready/mem_data back to the
// granted cache only. A one-cycle RELEASE follows every completion so the
// finished cache can drop its strobe before the next grant.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   cache_mem_arbiter_if.master (cache request/response and memory port)
// Configuration macro ARB_RR_EN:
//   defined   - on a tie the cache that did not win last time is granted
//   undefined - i_cache has priority; d_cache wins a tie once i_cache has been
//               granted MAX_I_STREAK times in a row while d_cache was waiting
module cache_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_I_STREAK = 4
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t state, state_next;

  logic last_gnt_d;   // 1: most recent grant went to d_cache
  logic gnt_i, gnt_d;

  logic [ADDR_W-1:0] mem_a_q;
  logic              mem_write_q;
  logic [1:0]        mem_size_q;
  logic [3:0]        mem_sel_q;
  logic [DATA_W-1:0] mem_st_data_q;
  logic [DATA_W-1:0] i_data_q;
  logic [DATA_W-1:0] d_rdata_q;

`ifndef ARB_RR_EN
  localparam int SW = $clog2(MAX_I_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_I_STREAK);
  logic [SW-1:0] streak;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_strobe && bus.d_strobe) begin
`ifdef ARB_RR_EN
          gnt_d = ~last_gnt_d;
          gnt_i = last_gnt_d;
`else
          gnt_d = (streak == STREAK_MAX);
          gnt_i = (streak != STREAK_MAX);
`endif
        end else begin
          gnt_i = bus.i_strobe;
          gnt_d = bus.d_strobe;
        end
        if (gnt_i) begin
          state_next = BUSY_I;
        end else if (gnt_d) begin
          state_next = BUSY_D;
        end
      end
      BUSY_I:  if (bus.mem_ready) state_next = RELEASE;
      BUSY_D:  if (bus.mem_ready) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture on the grant edge; the registers stay frozen until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_a_q       <= '0;
      mem_write_q   <= 1'b0;
      mem_size_q    <= 2'b00;
      mem_sel_q     <= 4'b0000;
      mem_st_data_q <= '0;
      last_gnt_d    <= 1'b1;
    end else if (gnt_i) begin
      mem_a_q       <= bus.i_addr;
      mem_write_q   <= 1'b0;
      mem_size_q    <= 2'b10;
      mem_sel_q     <= 4'b1111;
      mem_st_data_q <= '0;
      last_gnt_d    <= 1'b0;
    end else if (gnt_d) begin
      mem_a_q       <= bus.d_addr;
      mem_write_q   <= bus.d_rw;
      mem_size_q    <= bus.d_size;
      mem_sel_q     <= bus.d_wen;
      mem_st_data_q <= bus.d_wdata;
      last_gnt_d    <= 1'b1;
    end
  end

`ifndef ARB_RR_EN
  // Counts I grants made while d_cache was waiting; d_cache is forced in once it saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (gnt_d) begin
      streak <= '0;
    end else if (gnt_i) begin
      if (!bus.d_strobe) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 1'b1;
      end
    end
  end
`endif

  // Read data holders so each cache's data output keeps its last delivered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      if (bus.i_ready) i_data_q  <= bus.mem_data;
      if (bus.d_ready) d_rdata_q <= bus.mem_data;
    end
  end

  assign bus.mem_access  = (state == BUSY_I) || (state == BUSY_D);
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_size    = mem_size_q;
  assign bus.mem_sel     = mem_sel_q;
  assign bus.mem_st_data = mem_st_data_q;

  // Completion is passed through in the same cycle as mem_ready.
  assign bus.i_ready = (state == BUSY_I) && bus.mem_ready;
  assign bus.d_ready = (state == BUSY_D) && bus.mem_ready;
  assign bus.i_data  = bus.i_ready ? bus.mem_data : i_data_q;
  assign bus.d_rdata = bus.d_ready ? bus.mem_data : d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_I_STREAK(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one optional outstanding transaction record plus a cooldown count.
  bit          m_active;
  bit          m_own_d;
  logic [31:0] m_a, m_st;
  logic        m_write;
  logic [1:0]  m_size;
  logic [3:0]  m_sel;
  int          m_cool;
  logic [31:0] m_li, m_ld;
  bit          m_last_d;
  int          m_i_run;

  task automatic model_reset();
    m_active = 0; m_own_d = 0; m_cool = 0;
    m_li = '0; m_ld = '0; m_last_d = 1; m_i_run = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    logic ei, ed;
    bit pick_d;
    if (rst) model_reset();
    ei = m_active && !m_own_d && bus.mem_ready;
    ed = m_active &&  m_own_d && bus.mem_ready;
    check("mem_access", {31'd0, bus.mem_access}, {31'd0, m_active});
    check("i_ready", {31'd0, bus.i_ready}, {31'd0, ei});
    check("d_ready", {31'd0, bus.d_ready}, {31'd0, ed});
    check("i_data", bus.i_data, ei ? bus.mem_data : m_li);
    check("d_rdata", bus.d_rdata, ed ? bus.mem_data : m_ld);
    if (m_active) begin
      check("mem_a", bus.mem_a, m_a);
      check("mem_write", {31'd0, bus.mem_write}, {31'd0, m_write});
      check("mem_size", {30'd0, bus.mem_size}, {30'd0, m_size});
      check("mem_sel", {28'd0, bus.mem_sel}, {28'd0, m_sel});
      if (m_own_d) check("mem_st_data", bus.mem_st_data, m_st);
    end
    if (!rst) begin
      if (m_active) begin
        if (bus.mem_ready) begin
          if (m_own_d) m_ld = bus.mem_data; else m_li = bus.mem_data;
          m_active = 0;
          m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (bus.i_strobe || bus.d_strobe) begin
        if (bus.i_strobe && bus.d_strobe) begin
`ifdef ARB_RR_EN
          pick_d = !m_last_d;
`else
          pick_d = (m_i_run >= MAXS);
`endif
        end else begin
          pick_d = bus.d_strobe;
        end
        m_active = 1;
        m_own_d = pick_d;
        m_last_d = pick_d;
        if (pick_d) begin
          m_a = bus.d_addr; m_write = bus.d_rw; m_size = bus.d_size;
          m_sel = bus.d_wen; m_st = bus.d_wdata; m_i_run = 0;
        end else begin
          m_a = bus.i_addr; m_write = 0; m_size = 2'b10; m_sel = 4'hF;
          m_i_run = bus.d_strobe ? m_i_run + 1 : 0;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_strobe = 0; bus.i_addr = '0;
    bus.d_strobe = 0; bus.d_addr = '0; bus.d_rw = 0; bus.d_size = 2'b00;
    bus.d_wen = 4'h0; bus.d_wdata = '0;
    bus.mem_ready = 0; bus.mem_data = '0;
  endtask

  // Waits for a grant, completes it, and reports whether i_cache owned it.
  task automatic serve(output bit is_i, output bit ok);
    ok = 0; is_i = 0;
    for (int k = 0; k < 8; k++) begin
      smp();
      if (bus.mem_access) begin
        ok = 1;
        is_i = (bus.mem_size == 2'b10);
        break;
      end
      nxt();
    end
    if (ok) begin
      nxt(); bus.mem_ready = 1; bus.mem_data = $urandom;
      smp();
      nxt(); bus.mem_ready = 0;
    end else begin
      check("grant_timeout", 32'd0, 32'd1);
    end
  endtask

  bit exp_i[6];
  bit got_i, ok;

  initial begin
    rst = 1;
    clear_inputs();
    nxt(); nxt();
    smp();
    check("rst_mem_access", {31'd0, bus.mem_access}, 32'd0);
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_sel", {28'd0, bus.mem_sel}, 32'd0);
    check("rst_i_data", bus.i_data, 32'd0);

    // Instruction fetch from the boot vector.
    nxt(); rst = 0;
    bus.i_strobe = 1; bus.i_addr = 32'hBFC0_0000;
    smp();
    check("t1_latency", {31'd0, bus.mem_access}, 32'd0);
    nxt();
    smp();
    check("t1_access", {31'd0, bus.mem_access}, 32'd1);
    check("t1_mem_a", bus.mem_a, 32'hBFC0_0000);
    check("t1_sel", {28'd0, bus.mem_sel}, 32'hF);
    check("t1_size", {30'd0, bus.mem_size}, 32'd2);
    nxt(); bus.mem_ready = 1; bus.mem_data = 32'h3C1D_BFC0;
    smp();
    check("t1_i_ready", {31'd0, bus.i_ready}, 32'd1);
    check("t1_i_data", bus.i_data, 32'h3C1D_BFC0);
    nxt(); bus.mem_ready = 0; bus.i_strobe = 0;
    smp();
    check("t1_release", {31'd0, bus.mem_access}, 32'd0);
    check("t1_i_data_hold", bus.i_data, 32'h3C1D_BFC0);

    // Half-word store.
    nxt();
    bus.d_strobe = 1; bus.d_addr = 32'h8000_1000; bus.d_rw = 1;
    bus.d_wen = 4'h3; bus.d_size = 2'b01; bus.d_wdata = 32'h1234;
    nxt();
    smp();
    check("t2_write", {31'd0, bus.mem_write}, 32'd1);
    check("t2_sel", {28'd0, bus.mem_sel}, 32'h3);
    check("t2_st_data", bus.mem_st_data, 32'h1234);
    nxt(); bus.mem_ready = 1; bus.mem_data = 32'h0;
    smp();
    check("t2_d_ready", {31'd0, bus.d_ready}, 32'd1);
    check("t2_i_ready", {31'd0, bus.i_ready}, 32'd0);
    nxt(); bus.mem_ready = 0; bus.d_strobe = 0;
    smp();
    check("t2_d_ready_pulse", {31'd0, bus.d_ready}, 32'd0);

    // Both caches requesting continuously.
    nxt();
    bus.d_rw = 0; bus.d_size = 2'b00; bus.d_wen = 4'h1;
    bus.i_strobe = 1; bus.d_strobe = 1;
`ifdef ARB_RR_EN
    exp_i[0] = 1; exp_i[1] = 0; exp_i[2] = 1; exp_i[3] = 0; exp_i[4] = 1; exp_i[5] = 0;
`else
    exp_i[0] = 1; exp_i[1] = 1; exp_i[2] = 1; exp_i[3] = 1; exp_i[4] = 0; exp_i[5] = 1;
`endif
    for (int n = 0; n < 6; n++) begin
      serve(got_i, ok);
      check($sformatf("t3_grant%0d_is_i", n), {31'd0, got_i}, {31'd0, exp_i[n]});
    end
    bus.i_strobe = 0; bus.d_strobe = 0;
    nxt(); nxt();

    // Fetch whose strobe and address change mid-transaction.
    bus.i_strobe = 1; bus.i_addr = 32'h0040_0000;
    nxt();
    bus.i_strobe = 0; bus.i_addr = 32'h0;
    smp();
    check("t4_mem_a_frozen", bus.mem_a, 32'h0040_0000);
    nxt(); bus.mem_ready = 1; bus.mem_data = 32'hA5A5_0001;
    smp();
    check("t4_i_ready", {31'd0, bus.i_ready}, 32'd1);
    nxt(); bus.mem_ready = 0;
    nxt();

    // Reset during a data read.
    bus.d_strobe = 1; bus.d_addr = 32'h8000_2000; bus.d_rw = 0; bus.d_size = 2'b10;
    nxt();
    smp();
    check("t5_busy", {31'd0, bus.mem_access}, 32'd1);
    nxt(); rst = 1; bus.d_strobe = 0;
    smp();
    check("t5_abort", {31'd0, bus.mem_access}, 32'd0);
    nxt(); rst = 0; bus.mem_ready = 1;
    smp();
    check("t5_no_d_ready", {31'd0, bus.d_ready}, 32'd0);
    nxt(); bus.mem_ready = 0;
    bus.i_strobe = 1; bus.i_addr = 32'h0000_0100;
    nxt();
    smp();
    check("t5_regrant", bus.mem_a, 32'h0000_0100);
    nxt(); bus.mem_ready = 1; bus.i_strobe = 0;
    nxt(); bus.mem_ready = 0;

    // mem_ready noise with nobody requesting.
    bus.mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      smp();
      check("t6_no_grant", {31'd0, bus.mem_access}, 32'd0);
      nxt();
    end
    bus.mem_ready = 0;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst = ($urandom_range(0, 199) == 0);
      bus.i_strobe = ($urandom_range(0, 9) < 6);
      bus.d_strobe = ($urandom_range(0, 9) < 6);
      bus.i_addr = $urandom;
      bus.d_addr = $urandom;
      bus.d_rw = $urandom_range(0, 1);
      bus.d_size = 2'($urandom_range(0, 2));
      bus.d_wen = 4'($urandom);
      bus.d_wdata = $urandom;
      bus.mem_ready = ($urandom_range(0, 9) < 4);
      bus.mem_data = $urandom;
    end
    nxt(); rst = 0;
    clear_inputs();
    nxt(); nxt();
    smp();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
